// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA sync receiver.
//   - Default 800x600@72 timing (50 MHz pixel clock) and derived totals.
//   - Coordinate width and saturation value of the position counters.
//   - Lock FSM state type.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 56;
  localparam int H_SW_DEF     = 120;
  localparam int H_BP_DEF     = 64;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SW_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 37;
  localparam int V_SW_DEF     = 6;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SW_DEF + V_BP_DEF;

  localparam int               POS_W   = 11;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: leading-edge detector for one sync line.
//   Optional build macro VGA_SYNC_RX_SYNC_EN inserts a 2-flop synchronizer
//   (reset to the deasserted level) ahead of the edge detector.
// Ports:
//   clk_i   pixel clock
//   rst_i   asynchronous active-high reset
//   sync_i  raw sync line
//   edge_o  high for the cycle in which the sampled line first shows SYNC_POL
module sync_edge
  import vga_pkg::*;
#(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic edge_o
);

  logic samp;
  logic samp_vld;

`ifdef VGA_SYNC_RX_SYNC_EN
  logic       meta_q;
  logic       sync_q;
  logic [1:0] vld_q;

  // vld_q marks when the chain holds real input rather than reset values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= !SYNC_POL;
      sync_q <= !SYNC_POL;
      vld_q  <= 2'b00;
    end else begin
      meta_q <= sync_i;
      sync_q <= meta_q;
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

  assign samp     = sync_q;
  assign samp_vld = vld_q[1];
`else
  assign samp     = sync_i;
  assign samp_vld = 1'b1;
`endif

  logic prev_q;
  logic arm_q;

  // arm_q: an edge is only accepted once a genuine deasserted sample has been
  // seen since reset, so a sync held asserted across reset release is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= !SYNC_POL;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= samp;
      if (samp_vld && (samp != SYNC_POL)) arm_q <= 1'b1;
    end
  end

  assign edge_o = arm_q && samp_vld && (samp == SYNC_POL) && (prev_q != SYNC_POL);

endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers active-area coordinates from hsync/vsync and tracks
// whether the incoming timing matches the configured mode.
//   Build macro VGA_SYNC_RX_SYNC_EN: adds a 2-flop input synchronizer
//   (2 extra cycles of latency on every output).
// Ports:
//   clk_i, rst_i          pixel clock, asynchronous active-high reset
//   hsync_i, vsync_i      sync lines
//   x_o, y_o, de_o        active coordinates and data enable (registered)
//   frame_start_o         one-cycle pulse per vsync leading edge
//   locked_o, err_o       lock status, one-cycle timing error pulse
//   h_total_o, v_total_o  last measured line (clocks) / frame (lines) period
//
// Lock FSM
//   state      | meaning
//   SEARCH     | no reference yet; wait for a vsync edge
//   ACQUIRE    | counting consecutive good frames
//   LOCKED     | timing matches parameters
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SW        = H_SW_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SW        = V_SW_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o,
  output logic             de_o,
  output logic             frame_start_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [POS_W-1:0] h_total_o,
  output logic [POS_W-1:0] v_total_o
);

  localparam logic [POS_W-1:0] H_TOT   = POS_W'(H_ACTIVE + H_FP + H_SW + H_BP);
  localparam logic [POS_W-1:0] V_TOT   = POS_W'(V_ACTIVE + V_FP + V_SW + V_BP);
  localparam logic [POS_W-1:0] H_START = POS_W'(H_SW + H_BP);
  localparam logic [POS_W-1:0] H_END   = POS_W'(H_SW + H_BP + H_ACTIVE);
  localparam logic [POS_W-1:0] V_START = POS_W'(V_SW + V_BP);
  localparam logic [POS_W-1:0] V_END   = POS_W'(V_SW + V_BP + V_ACTIVE);
  localparam int               CNT_W   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  logic hs_edge, vs_edge;

  sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk_i (clk_i), .rst_i (rst_i), .sync_i (hsync_i), .edge_o (hs_edge)
  );
  sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk_i (clk_i), .rst_i (rst_i), .sync_i (vsync_i), .edge_o (vs_edge)
  );

  logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [POS_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             de_q, de_d, fs_q;
  logic [POS_W-1:0] hlen, vlen;
  logic             h_act, v_act;

  // Period of the span just closed; clamp so a saturated counter never wraps to 0.
  assign hlen = (hpos_q == POS_MAX) ? POS_MAX : hpos_q + 1'b1;
  assign vlen = (vpos_q == POS_MAX) ? POS_MAX : vpos_q + 1'b1;

  assign h_act = (hpos_q >= H_START) && (hpos_q < H_END);
  assign v_act = (vpos_q >= V_START) && (vpos_q < V_END);

  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    h_total_d = h_total_q;
    v_total_d = v_total_q;
    if (hs_edge)                  hpos_d = '0;
    else if (hpos_q != POS_MAX)   hpos_d = hpos_q + 1'b1;
    // vsync edge wins over a coincident hsync edge.
    if (vs_edge)                            vpos_d = '0;
    else if (hs_edge && vpos_q != POS_MAX)  vpos_d = vpos_q + 1'b1;
    if (hs_edge) h_total_d = hlen;
    if (vs_edge) v_total_d = vlen;
    de_d = h_act && v_act;
    x_d  = de_d ? hpos_q - H_START : '0;
    y_d  = de_d ? vpos_q - V_START : '0;
  end

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_line_q, bad_line_d;
  logic             err_q, err_d;
  logic             line_bad, frame_bad, lost;

  assign line_bad  = hs_edge && (hlen != H_TOT);
  assign frame_bad = bad_line_q || line_bad || (vlen != V_TOT);
  assign lost      = (hpos_q == POS_MAX) || (vpos_q == POS_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    bad_line_d = bad_line_q;
    if (vs_edge)       bad_line_d = 1'b0;
    else if (line_bad) bad_line_d = 1'b1;

    if (lost) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      err_d   = (state_q == ST_LOCKED);
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (vs_edge) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
          end
        end
        ST_ACQUIRE: begin
          if (vs_edge) begin
            if (frame_bad) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_d == CNT_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (vs_edge && frame_bad) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
            // A bad line in this frame already raised err; report each fault once.
            err_d   = !bad_line_q;
          end else if (line_bad) begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hpos_q     <= '0;
      vpos_q     <= '0;
      h_total_q  <= '0;
      v_total_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      state_q    <= ST_SEARCH;
      cnt_q      <= '0;
      bad_line_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      x_q        <= x_d;
      y_q        <= y_d;
      de_q       <= de_d;
      fs_q       <= vs_edge;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_line_q <= bad_line_d;
      err_q      <= err_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign locked_o      = (state_q == ST_LOCKED);
  assign err_o         = err_q;
  assign h_total_o     = h_total_q;
  assign v_total_o     = v_total_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives a behavioural VGA timing generator (small mode) into
// vga_sync_rx and checks coordinates, lock behaviour, error pulses and reset.
module tb_vga_sync_rx;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5, HT = HA + HF + HS + HB;  // 31
  localparam int VA = 10, VF = 2, VS = 3, VB = 4, VT = VA + VF + VS + VB;  // 19
  localparam bit POL = 1'b1;
`ifdef VGA_SYNC_RX_SYNC_EN
  localparam int DLY = 3;  // generator-to-output latency 4, minus the sample offset
`else
  localparam int DLY = 1;  // generator-to-output latency 2, minus the sample offset
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hsync_i, vsync_i;
  logic [10:0] x_o, y_o, h_total_o, v_total_o;
  logic        de_o, frame_start_o, locked_o, err_o;

  always #5 clk_i = ~clk_i;

  vga_sync_rx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB),
    .SYNC_POL(POL), .LOCK_FRAMES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .x_o(x_o), .y_o(y_o), .de_o(de_o), .frame_start_o(frame_start_o),
    .locked_o(locked_o), .err_o(err_o), .h_total_o(h_total_o), .v_total_o(v_total_o)
  );

  int n_cmp = 0, n_mis = 0;
  int hc = 0, vc = 0;
  int fs_n = 0, err_cnt = 0;
  bit fs_prev = 0, cmp_en = 0, cmp_allow = 0;
  bit stretch_req = 0;
  int str_line = 0;
  logic [22:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {de,x,y} for a generator position: active area is the top-left VAxHA.
  function automatic logic [22:0] pix_at(input int h, input int v);
    if (h < HA && v < VA) return {1'b1, 11'(h), 11'(v)};
    return '0;
  endfunction

  // hsync occupies [HA+HF, HA+HF+HS) of each line; vsync changes together with
  // the hsync leading edge so that each frame closes on a coincident edge pair.
  task automatic drive();
    int vs_line;
    hsync_i = (hc >= HA + HF && hc < HA + HF + HS) ? POL : !POL;
    vs_line = (hc >= HA + HF) ? (vc + 1) % VT : vc;
    vsync_i = (vs_line >= VA + VF && vs_line < VA + VF + VS) ? POL : !POL;
  endtask

  task automatic advance();
    if (stretch_req && vc == str_line && hc == HA) stretch_req = 0;  // repeat one clock
    else if (hc == HT - 1) begin hc = 0; vc = (vc + 1) % VT; end
    else hc++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (err_o) err_cnt++;
    if (cmp_en && hist.size() > DLY)
      chk("pix", {9'd0, de_o, x_o, y_o}, {9'd0, hist[hist.size() - 1 - DLY]});
    if (frame_start_o) begin
      chk("fs_width", {31'd0, fs_prev}, 32'd0);
      fs_n++;
      cmp_en = cmp_allow;
    end
    fs_prev = frame_start_o;
  endtask

  task automatic gen_cycle();
    drive();
    hist.push_back(pix_at(hc, vc));
    if (hist.size() > 8) void'(hist.pop_front());
    advance();
    tick();
  endtask

  task automatic run_until_fs(input int target);
    int n = 0;
    while (fs_n < target && n < 2 * VT * HT + 32) begin
      gen_cycle();
      n++;
    end
    chk("fs_reached", fs_n, target);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_x"}, {21'd0, x_o}, 0);
    chk({pfx, "_y"}, {21'd0, y_o}, 0);
    chk({pfx, "_de"}, {31'd0, de_o}, 0);
    chk({pfx, "_fs"}, {31'd0, frame_start_o}, 0);
    chk({pfx, "_locked"}, {31'd0, locked_o}, 0);
    chk({pfx, "_err"}, {31'd0, err_o}, 0);
    chk({pfx, "_htot"}, {21'd0, h_total_o}, 0);
    chk({pfx, "_vtot"}, {21'd0, v_total_o}, 0);
  endtask

  initial begin
    int e0, fs0, n;
    rst_i = 1'b1;
    hc = 0; vc = 0;
    drive();
    repeat (3) @(posedge clk_i);
    #1;
    chk_zero("rst");
    rst_i = 1'b0;
    cmp_allow = 1;

    // Acquisition: lock is reached at the second frame_start after the first.
    run_until_fs(1);
    chk("lock_f1", {31'd0, locked_o}, 0);
    run_until_fs(2);
    chk("lock_f2", {31'd0, locked_o}, 0);
    chk("v_total", {21'd0, v_total_o}, VT);
    chk("h_total", {21'd0, h_total_o}, HT);
    run_until_fs(3);
    chk("lock_f3", {31'd0, locked_o}, 1);
    run_until_fs(5);
    chk("lock_f5", {31'd0, locked_o}, 1);
    chk("err_clean", err_cnt, 0);

    // One stretched line: one err pulse, unlock at frame close, relock 2 frames later.
    e0 = err_cnt;
    str_line = $urandom_range(0, VA + VF - 2);
    stretch_req = 1;
    run_until_fs(6);
    chk("str_err_once", err_cnt - e0, 1);
    chk("str_unlock", {31'd0, locked_o}, 0);
    chk("str_htot", {21'd0, h_total_o}, HT);
    run_until_fs(7);
    chk("str_acq", {31'd0, locked_o}, 0);
    run_until_fs(8);
    chk("str_relock", {31'd0, locked_o}, 1);
    chk("str_err_total", err_cnt - e0, 1);

    // Sync loss: both syncs idle long enough to saturate the line counter.
    e0 = err_cnt;
    cmp_en = 0;
    cmp_allow = 0;
    hist.delete();
    hsync_i = !POL;
    vsync_i = !POL;
    n = 2100 + $urandom_range(0, 100);
    repeat (n) tick();
    chk("loss_unlock", {31'd0, locked_o}, 0);
    chk("loss_err_once", err_cnt - e0, 1);
    hc = $urandom_range(0, HT - 1);
    vc = $urandom_range(0, VA + VF - 2);
    cmp_allow = 1;
    fs0 = fs_n;
    run_until_fs(fs0 + 1);
    chk("loss_f1", {31'd0, locked_o}, 0);
    run_until_fs(fs0 + 2);
    chk("loss_f2", {31'd0, locked_o}, 0);
    run_until_fs(fs0 + 3);
    chk("loss_relock", {31'd0, locked_o}, 1);
    chk("loss_err_total", err_cnt - e0, 1);

    // Reset mid-frame while hsync is asserted; release before hsync falls.
    cmp_allow = 0;
    cmp_en = 0;
    n = 0;
    while (hc != HA + HF + 2 && n < 2 * HT) begin gen_cycle(); n++; end
    chk("rst_pos", hc, HA + HF + 2);
    drive();
    rst_i = 1'b1;
    #1;
    chk_zero("mid_rst");
    gen_cycle();
    rst_i = 1'b0;
    fs0 = fs_n;
    n = 0;
    while (hc != HA + HF && n < 2 * HT) begin gen_cycle(); n++; end
    chk("no_false_edge", {21'd0, h_total_o}, 0);
    chk("no_false_fs", fs_n - fs0, 0);
    repeat (HT + 5) gen_cycle();
    chk("post_rst_htot", {21'd0, h_total_o}, HT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameters H_FP 56, H_SW 120, H_BP 64: front porch, sync width and back porch in clocks (H_TOTAL = 1040).
REQ-003 SHALL have parameters V_ACTIVE 600, V_FP 37, V_SW 6, V_BP 23: the same quantities in lines (V_TOTAL = 666).
REQ-004 SHALL have parameter SYNC_POL, default 1, asserted level of hsync/vsync.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required for lock.
REQ-006 clk  input  1  pixel clock; single clock domain.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 hsync, vsync  input  1 each  sync lines as produced by vga_sync.
REQ-009 x, y  output  11 each  recovered active-area coordinates.
REQ-010 de  output  1  high while (x,y) is inside the active area.
REQ-011 frame_start  output  1  one-cycle pulse on each vsync leading edge.
REQ-012 locked  output  1  timing matches parameters.
REQ-013 err  output  1  one-cycle pulse on a timing mismatch while locked.
REQ-014 h_total, v_total  output  11 each  last measured line period (clocks) and frame period (lines).

Function
REQ-015 Leading edge SHALL be detected when the sampled sync changes from !SYNC_POL to SYNC_POL, using a registered previous-sample flop.
REQ-016 hpos (11 bits) SHALL be 0 on the hsync leading-edge cycle and SHALL increment each cycle after it, saturating at 2047.
REQ-017 vpos SHALL be 0 on a vsync leading-edge cycle, including one coincident with an hsync edge; otherwise it SHALL increment on each hsync edge, saturating at 2047.
REQ-018 On an hsync edge, h_total SHALL load the previous hpos+1; on a vsync edge, v_total SHALL load the previous vpos+1.
REQ-019 de SHALL be asserted when hpos lies in [H_SW+H_BP, H_SW+H_BP+H_ACTIVE) and vpos lies in [V_SW+V_BP, V_SW+V_BP+V_ACTIVE).
REQ-020 x and y SHALL equal hpos-(H_SW+H_BP) and vpos-(V_SW+V_BP) when de is high, and SHALL hold 0 when de is low.
REQ-021 x, y, de and frame_start SHALL be registered, with one-cycle latency from the hpos/vpos update.
REQ-022 Lock FSM states SHALL be SEARCH, ACQUIRE and LOCKED; reset state SHALL be SEARCH.
REQ-023 SEARCH SHALL move to ACQUIRE on the first vsync edge and clear the match count.
REQ-024 A frame SHALL be good when every line closed in it gave hpos+1 == H_TOTAL and the closing vsync edge gives vpos+1 == V_TOTAL; a sticky bad_line flag is cleared at each vsync edge.
REQ-025 ACQUIRE SHALL increment the match count on each good frame, go to LOCKED when count reaches LOCK_FRAMES, and reset the count on a bad frame.
REQ-026 LOCKED SHALL drop to ACQUIRE with count 0 and pulse err on a bad frame; on a bad line it SHALL pulse err immediately and stay LOCKED until the frame closes.
REQ-027 From any state, hpos or vpos saturation (sync lost) SHALL force SEARCH, deassert locked and pulse err if it was LOCKED.
REQ-028 locked SHALL be high exactly when the state is LOCKED.

Reset
REQ-029 rst SHALL asynchronously clear all flops: x=0, y=0, de=0, frame_start=0, locked=0, err=0, h_total=0, v_total=0, hpos=vpos=0, state SEARCH.
REQ-030 The previous-sample flops SHALL reset to !SYNC_POL, so a sync held asserted through reset release is not taken as an edge.

Configuration
REQ-031 Macro VGA_SYNC_RX_SYNC_EN: when defined, hsync/vsync SHALL pass through a 2-flop synchronizer (reset to !SYNC_POL) before edge detection, adding 2 cycles of latency to all outputs.
REQ-032 When VGA_SYNC_RX_SYNC_EN is undefined, inputs SHALL be sampled directly with no added latency.

Structure
REQ-033 Package vga_pkg SHALL hold the default timing constants (800x600@72, 50 MHz), the derived H_TOTAL/V_TOTAL and the lock FSM state typedef.
REQ-034 A single sub-module sync_edge SHALL provide the optional synchronizer, the previous-sample flop and the leading-edge output; it is instantiated once per sync line.

Verification
REQ-035 Drive vga_sync output into vga_sync_rx (defaults) -> locked rises on the 2nd vsync edge after the first; then x/y equal the generator's active coordinates every de cycle.
REQ-036 After lock, stretch one line to 1041 clocks -> err pulses once at the end of that line, locked drops at the next vsync edge, and relock follows 2 good frames later.
REQ-037 Hold hsync deasserted for 2100 clocks -> state SEARCH, locked=0, a single err pulse.
REQ-038 Assert rst mid-frame, with hsync asserted across release -> all outputs are 0, and no edge is seen until the next genuine leading edge.
REQ-039 Apply coincident hsync and vsync edges -> vpos=0, frame_start one cycle wide, v_total=666.
REQ-040 Build with VGA_SYNC_RX_SYNC_EN and rerun REQ-035 -> identical x/y/de sequence, delayed by exactly 2 cycles.
